// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline control unit.
// State encoding, pipeline register enable bundle, default memory timeout.
package pipeline_pkg;

   localparam int TIMEOUT_DEF = 15;
   localparam int REG_W       = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } state_t;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_HOLD   = 7'b00000_00;
   localparam ctrl_t CTRL_NORMAL = 7'b11111_00;
   localparam ctrl_t CTRL_BRANCH = 7'b11111_11;
   localparam ctrl_t CTRL_LOAD   = 7'b00111_01;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the load in EX and the operands in ID.
// Register 0 is hardwired, so a load into it never creates a dependency.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_ex_mem_read,
   input  logic [REG_W-1:0] id_ex_rt,
   output logic             load_use
);

   assign load_use = id_ex_mem_read
                   && (id_ex_rt != '0)
                   && ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory wait FSM with timeout,
// branch and load-use hazard handling, saturating stall counter.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_ex_mem_read,
   input  logic [REG_W-1:0] id_ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       state,
   output logic             err,
   output logic [15:0]      stall_cnt
);

   localparam logic [4:0] TO_LIMIT = 5'(TIMEOUT);

   state_t      state_q;
   logic [3:0]  wait_cnt;
   logic [4:0]  wait_nxt;
   logic        err_q;
   logic [15:0] stall_q;
   logic        load_use;
   logic        active;
   logic        mem_stall;
   ctrl_t       ctrl;

   hazard_detect u_hazard (
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rt       (id_ex_rt),
      .load_use       (load_use)
   );

   assign active    = (state_q == RUN) || (state_q == MEM_WAIT);
   assign mem_stall = ((state_q == RUN) && mem_access && !dmem_ack)
                   || ((state_q == MEM_WAIT) && !dmem_ack);
   assign wait_nxt  = {1'b0, wait_cnt} + 5'd1;

   always_comb begin
      ctrl     = CTRL_HOLD;
      dmem_req = 1'b0;
      if (active) begin
         dmem_req = (state_q == MEM_WAIT) || mem_access;
         if (mem_stall)
            ctrl = CTRL_HOLD;
         else if (ex_branch_taken)
            ctrl = CTRL_BRANCH;
         else if (load_use)
            ctrl = CTRL_LOAD;
         else
            ctrl = CTRL_NORMAL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wait_cnt <= '0;
         err_q    <= 1'b0;
         stall_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: state_q <= RUN;
            RUN: begin
               if (mem_access && !dmem_ack) begin
                  state_q  <= MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (dmem_ack) begin
                  state_q <= RUN;
               end else begin
                  wait_cnt <= wait_nxt[3:0];
                  if (wait_nxt == TO_LIMIT) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            ERR: err_q <= 1'b1;
            default: state_q <= IDLE;
         endcase
         // Saturate rather than wrap so long stalls never look short.
         if (active && !ctrl.pc && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
      end
   end

   assign pc_en       = ctrl.pc;
   assign if_id_en    = ctrl.if_id;
   assign id_ex_en    = ctrl.id_ex;
   assign ex_mem_en   = ctrl.ex_mem;
   assign mem_wb_en   = ctrl.mem_wb;
   assign if_id_flush = ctrl.if_id_flush;
   assign id_ex_flush = ctrl.id_ex_flush;
   assign state       = state_q;
   assign err         = err_q;
   assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with an expected-value queue.
// Inputs change on the falling edge; outputs are compared mid low phase.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic [1:0]  st;
      logic [6:0]  ctl;
      logic        req;
      logic        er;
      logic [15:0] sc;
   } exp_t;

   localparam logic [6:0] HOLD = 7'b00000_00;
   localparam logic [6:0] NORM = 7'b11111_00;
   localparam logic [6:0] BRCH = 7'b11111_11;
   localparam logic [6:0] LDUS = 7'b00111_01;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, id_ex_rt;
   logic        id_ex_mem_read, ex_branch_taken;
   logic        mem_access, dmem_ack;
   logic        dmem_req, pc_en, if_id_en, id_ex_en;
   logic        ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
   logic [1:0]  state;
   logic        err;
   logic [15:0] stall_cnt;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_sc = 16'd0;
   exp_t        sbq[$];

   pipeline_ctrl #(.TIMEOUT(15)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_rt        (id_ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .mem_access      (mem_access),
      .dmem_ack        (dmem_ack),
      .dmem_req        (dmem_req),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .ex_mem_en       (ex_mem_en),
      .mem_wb_en       (mem_wb_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .state           (state),
      .err             (err),
      .stall_cnt       (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string tag, input logic [1:0] st,
                      input logic [6:0] ctl, input logic req,
                      input logic er);
      exp_t e;
      exp_t o;
      sbq.push_back('{st: st, ctl: ctl, req: req, er: er, sc: exp_sc});
      #2;
      e = sbq.pop_front();
      o = '{st: state,
            ctl: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush},
            req: dmem_req, er: err, sc: stall_cnt};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
      if ((st == 2'd1 || st == 2'd2) && !ctl[6] && exp_sc != 16'hFFFF)
         exp_sc = exp_sc + 16'd1;
      @(negedge clk);
   endtask

   task automatic set_in(input logic rd, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic ma,
                         input logic ack);
      id_ex_mem_read  = rd;
      id_ex_rt        = xrt;
      id_rs           = rs;
      id_rt           = rt;
      ex_branch_taken = br;
      mem_access      = ma;
      dmem_ack        = ack;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      cyc("reset", 2'd0, HOLD, 0, 0);
      rst_n = 1'b1;
      cyc("idle", 2'd0, HOLD, 0, 0);
      cyc("run", 2'd1, NORM, 0, 0);

      set_in(1, 5, 5, 0, 0, 0, 0);
      cyc("lu_rs", 2'd1, LDUS, 0, 0);
      set_in(0, 5, 5, 0, 0, 0, 0);
      cyc("lu_after", 2'd1, NORM, 0, 0);
      set_in(1, 0, 0, 0, 0, 0, 0);
      cyc("lu_r0", 2'd1, NORM, 0, 0);
      set_in(1, 7, 3, 7, 0, 0, 0);
      cyc("lu_rt", 2'd1, LDUS, 0, 0);
      set_in(1, 7, 3, 4, 0, 0, 0);
      cyc("lu_nomatch", 2'd1, NORM, 0, 0);

      set_in(1, 5, 5, 0, 1, 0, 0);
      cyc("br_lu", 2'd1, BRCH, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cyc("br_after", 2'd1, NORM, 0, 0);

      set_in(0, 0, 0, 0, 0, 1, 1);
      cyc("mem_fast", 2'd1, NORM, 1, 0);
      set_in(0, 0, 0, 0, 0, 1, 0);
      cyc("mw_run", 2'd1, HOLD, 1, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cyc("mw_wait1", 2'd2, HOLD, 1, 0);
      cyc("mw_wait2", 2'd2, HOLD, 1, 0);
      set_in(0, 0, 0, 0, 0, 0, 1);
      cyc("mw_ack", 2'd2, NORM, 1, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cyc("mw_back", 2'd1, NORM, 0, 0);

      set_in(0, 0, 0, 0, 0, 1, 0);
      cyc("mw2_run", 2'd1, HOLD, 1, 0);
      set_in(1, 9, 0, 9, 0, 0, 1);
      cyc("mw2_ack_lu", 2'd2, LDUS, 1, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cyc("mw2_back", 2'd1, NORM, 0, 0);

      set_in(0, 0, 0, 0, 0, 1, 0);
      cyc("to_run", 2'd1, HOLD, 1, 0);
      for (int i = 0; i < 15; i++)
         cyc("to_wait", 2'd2, HOLD, 1, 0);
      cyc("to_err", 2'd3, HOLD, 0, 1);
      set_in(1, 5, 5, 0, 1, 1, 1);
      cyc("err_hold", 2'd3, HOLD, 0, 1);

      rst_n = 1'b0;
      exp_sc = 16'd0;
      cyc("err_reset", 2'd0, HOLD, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc("re_idle", 2'd0, HOLD, 0, 0);
      cyc("re_run", 2'd1, NORM, 0, 0);

      set_in(1, 3, 3, 0, 0, 0, 0);
      repeat (65534) @(negedge clk);
      exp_sc = 16'hFFFE;
      cyc("sat_fffe", 2'd1, LDUS, 0, 0);
      cyc("sat_ffff", 2'd1, LDUS, 0, 0);
      cyc("sat_hold", 2'd1, LDUS, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cyc("sat_end", 2'd1, NORM, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
